// File: rtl/sym2_pkg.sv
// Shared definitions for the 2-bit symbol line code used by the encoder and decoder.
package sym2_pkg;

  localparam int SYM_W = 2;

  function automatic logic [SYM_W-1:0] sym2_encode(input logic [SYM_W-1:0] d);
    return {d[1] ^ ~d[0], ~d[0]};
  endfunction

  function automatic logic [SYM_W-1:0] sym2_decode(input logic [SYM_W-1:0] e);
    return {e[1] ^ e[0], ~e[0]};
  endfunction

endpackage

// File: rtl/sym2_decode_slot.sv
// Combinational decode of a single encoded symbol.
module sym2_decode_slot
  import sym2_pkg::*;
(
  input  logic [SYM_W-1:0] enc,
  output logic [SYM_W-1:0] dec
);

  assign dec = sym2_decode(enc);

endmodule

// File: rtl/sym2_stream_decoder.sv
// Stream decoder: decodes accepted symbols and packs SYMS_PER_WORD of them per output word.
module sym2_stream_decoder
  import sym2_pkg::*;
#(
  parameter int SYMS_PER_WORD = 4,
  parameter int CNT_W         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SYM_W-1:0]                      in_sym,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SYM_W*SYMS_PER_WORD-1:0]        out_data,
  output logic [$clog2(SYMS_PER_WORD):0]        out_count,
  output logic [CNT_W-1:0]                      sym_count,
  output logic [CNT_W-1:0]                      word_count
);

  localparam int W     = SYM_W * SYMS_PER_WORD;
  localparam int IDX_W = $clog2(SYMS_PER_WORD);
  localparam int OC_W  = IDX_W + 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FILL  = 1'b1;

  logic [0:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] cur_idx_s;
  logic [W-1:0]     acc_r;
  logic [W-1:0]     acc_next_s;
  logic [SYM_W-1:0] dec_s;
  logic             out_valid_r;
  logic [W-1:0]     out_data_r;
  logic [OC_W-1:0]  out_count_r;
  logic [CNT_W-1:0] sym_count_r;
  logic [CNT_W-1:0] word_count_r;
  logic             accept_s;
  logic             drain_s;
  logic             complete_s;

  sym2_decode_slot u_slot (
    .enc (in_sym),
    .dec (dec_s)
  );

  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign drain_s    = out_valid_r && out_ready;
  assign complete_s = accept_s && (in_last || (cur_idx_s == IDX_W'(SYMS_PER_WORD - 1)));

  // Slot index is zero whenever no partial word is being built.
  always_comb begin
    cur_idx_s = '0;
    if (state_r == ST_FILL) begin
      cur_idx_s = idx_r;
    end else begin
      cur_idx_s = '0;
    end
  end

  // Accumulator with the new symbol merged in; slots above it are forced to zero.
  always_comb begin
    acc_next_s = '0;
    for (int k = 0; k < SYMS_PER_WORD; k++) begin
      if (IDX_W'(k) < cur_idx_s) begin
        acc_next_s[SYM_W*k +: SYM_W] = acc_r[SYM_W*k +: SYM_W];
      end else if (IDX_W'(k) == cur_idx_s) begin
        acc_next_s[SYM_W*k +: SYM_W] = dec_s;
      end else begin
        acc_next_s[SYM_W*k +: SYM_W] = '0;
      end
    end
  end

  // Fill FSM, output register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      idx_r        <= '0;
      acc_r        <= '0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_count_r  <= '0;
      sym_count_r  <= '0;
      word_count_r <= '0;
    end else begin
      if (accept_s) begin
        acc_r <= acc_next_s;
        if (complete_s) begin
          state_r <= ST_EMPTY;
          idx_r   <= '0;
        end else begin
          state_r <= ST_FILL;
          idx_r   <= cur_idx_s + IDX_W'(1);
        end
      end
      // A completing symbol overrides a same-cycle drain so the new word stays valid.
      if (complete_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_next_s;
        out_count_r <= OC_W'(cur_idx_s) + OC_W'(1);
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s) begin
        sym_count_r <= sym_count_r + CNT_W'(1);
      end
      if (drain_s) begin
        word_count_r <= word_count_r + CNT_W'(1);
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_count  = out_count_r;
  assign sym_count  = sym_count_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_sym2_stream_decoder.sv
// Directed self-checking bench for sym2_stream_decoder with SYMS_PER_WORD=4.
module tb_sym2_stream_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sym;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_count;
  logic [15:0] sym_count;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  logic stall_seen;

  sym2_stream_decoder #(.SYMS_PER_WORD(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sym     (in_sym),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .sym_count  (sym_count),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Present one symbol and return one step after the edge that accepts it.
  task automatic push(input logic [1:0] e, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sym   = e;
    in_last  = last;
    while (!in_ready && n < 50) begin
      stall_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'b00; in_last = 1'b0; out_ready = 1'b1;
    stall_seen = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_sym", 32'(sym_count), 32'd0);
    chk("rst_word", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Full word 11,00,01,10 -> E4
    push(2'b11, 1'b0); push(2'b00, 1'b0); push(2'b01, 1'b0);
    chk("full_pre_valid", 32'(out_valid), 32'd0);
    push(2'b10, 1'b0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_data", 32'(out_data), 32'hE4);
    chk("full_count", 32'(out_count), 32'd4);
    chk("full_sym", 32'(sym_count), 32'd4);
    step();
    chk("full_drained", 32'(out_valid), 32'd0);
    chk("full_word", 32'(word_count), 32'd1);
    chk("full_data_keep", 32'(out_data), 32'hE4);

    // Partial flush, then a one-symbol frame starting at slot 0
    push(2'b00, 1'b0); push(2'b00, 1'b1);
    chk("part_data", 32'(out_data), 32'h05);
    chk("part_count", 32'(out_count), 32'd2);
    push(2'b01, 1'b1);
    chk("first_last_data", 32'(out_data), 32'h02);
    chk("first_last_count", 32'(out_count), 32'd1);
    step();
    chk("part_word", 32'(word_count), 32'd3);
    chk("part_sym", 32'(sym_count), 32'd7);

    // Backpressure on a held E4 word
    out_ready = 1'b0;
    push(2'b11, 1'b0); push(2'b00, 1'b0); push(2'b01, 1'b0); push(2'b10, 1'b0);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_sym = 2'b11; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'hE4);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_hold_sym", 32'(sym_count), 32'd11);
    chk("bp_hold_count", 32'(out_count), 32'd4);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_swap_valid", 32'(out_valid), 32'd1);
    chk("bp_swap_data", 32'(out_data), 32'h00);
    chk("bp_swap_count", 32'(out_count), 32'd1);
    chk("bp_word", 32'(word_count), 32'd4);
    chk("bp_sym", 32'(sym_count), 32'd12);
    step();
    chk("bp_word2", 32'(word_count), 32'd5);

    // in_last on slot N-1: one full word, no empty extra word
    push(2'b00, 1'b0); push(2'b00, 1'b0); push(2'b00, 1'b0); push(2'b00, 1'b1);
    chk("lastfull_data", 32'(out_data), 32'h55);
    chk("lastfull_count", 32'(out_count), 32'd4);
    step(); step(); step();
    chk("lastfull_idle", 32'(out_valid), 32'd0);
    chk("lastfull_word", 32'(word_count), 32'd6);

    // Back-to-back stream of 8 symbols
    stall_seen = 1'b0;
    push(2'b10, 1'b0); push(2'b01, 1'b0); push(2'b00, 1'b0); push(2'b11, 1'b0);
    chk("b2b_w1_data", 32'(out_data), 32'h1B);
    chk("b2b_w1_valid", 32'(out_valid), 32'd1);
    push(2'b00, 1'b0); push(2'b00, 1'b0); push(2'b00, 1'b0);
    chk("b2b_gap", 32'(out_valid), 32'd0);
    push(2'b00, 1'b0);
    chk("b2b_w2_data", 32'(out_data), 32'h55);
    chk("b2b_stall", 32'(stall_seen), 32'd0);
    step();
    chk("b2b_word", 32'(word_count), 32'd8);
    chk("b2b_sym", 32'(sym_count), 32'd24);

    // Reset mid-fill drops the partial word
    push(2'b11, 1'b0); push(2'b11, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'h00);
    chk("mrst_count", 32'(out_count), 32'd0);
    chk("mrst_sym", 32'(sym_count), 32'd0);
    chk("mrst_word", 32'(word_count), 32'd0);
    push(2'b11, 1'b0); push(2'b11, 1'b0); push(2'b11, 1'b0);
    chk("mrst_no_early", 32'(out_valid), 32'd0);
    push(2'b11, 1'b0);
    chk("mrst_fill_data", 32'(out_data), 32'h00);
    chk("mrst_fill_count", 32'(out_count), 32'd4);
    step();

    // Counter wrap: stream up to 16'hFFFF accepts, then one more
    in_valid = 1'b1; in_sym = 2'b00; in_last = 1'b0;
    repeat (65531) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_ffff", 32'(sym_count), 32'hFFFF);
    push(2'b00, 1'b0);
    chk("wrap_zero", 32'(sym_count), 32'h0000);
    step();
    chk("wrap_word", 32'(word_count), 32'd16384);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
